// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, selectable read mode (registered or
// first-word-fall-through), synchronous flush and sticky error flags.
//
// Ports:
//   CLK          clock, all logic on rising edge
//   RST          synchronous reset, active-high (highest priority)
//   FLUSH        synchronous empty command (pointers/count/flags to reset)
//   CLR_ERR      clears OVERFLOW/UNDERFLOW (a same-cycle set wins)
//   W_INC        write request, accepted when not FULL
//   WR_DATA      write data
//   R_INC        read/pop request, accepted when not EMPTY
//   RD_DATA      read data (registered when FWFT=0, head word when FWFT=1)
//   RD_VALID     FWFT=0: pulse after an accepted read; FWFT=1: ~EMPTY
//   FULL/EMPTY   occupancy == DEPTH / == 0
//   ALMOST_FULL  COUNT >= AF_LEVEL
//   ALMOST_EMPTY COUNT <= AE_LEVEL
//   COUNT        occupancy 0..DEPTH
//   OVERFLOW     sticky: write attempted while FULL
//   UNDERFLOW    sticky: read attempted while EMPTY
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  CLR_ERR,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH + 1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > (2 ** ADDR_WIDTH)) begin : g_bad_af
    $error("sync_fifo_flex: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > (2 ** ADDR_WIDTH) - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_set;
  logic                  unf_set;
  logic [DATA_WIDTH-1:0] head;

  always_comb begin
    waddr = wptr[ADDR_WIDTH-1:0];
    raddr = rptr[ADDR_WIDTH-1:0];
    // Flags decode from registered pointers, so they reflect the previous edge.
    full  = (waddr == raddr) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    empty = (wptr == rptr);
    head  = mem[raddr];
  end

  // Requests in a flush or reset cycle are dropped and never raise errors.
  always_comb begin
    wr_en   = W_INC & ~full  & ~FLUSH & ~RST;
    rd_en   = R_INC & ~empty & ~FLUSH & ~RST;
    ovf_set = W_INC &  full  & ~FLUSH;
    unf_set = R_INC &  empty & ~FLUSH;
  end

  // Storage is deliberately left out of reset/flush.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[waddr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_set | (ovf_q & ~CLR_ERR);
      unf_q <= unf_set | (unf_q & ~CLR_ERR);
    end
  end

  always_comb begin
    FULL         = full;
    EMPTY        = empty;
    COUNT        = count_q;
    ALMOST_FULL  = (count_q >= AF_THR);
    ALMOST_EMPTY = (count_q <= AE_THR);
    OVERFLOW     = ovf_q;
    UNDERFLOW    = unf_q;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown while data is present; zero when empty so the
    // output matches its reset value instead of exposing stale storage.
    always_comb begin
      RD_VALID = ~empty;
      RD_DATA  = empty ? '0 : head;
    end
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (FLUSH) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_en;
        if (rd_en) begin
          rd_data_q <= head;
        end
      end
    end

    always_comb begin
      RD_VALID = rd_valid_q;
      RD_DATA  = rd_data_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       CLK = 1'b0;
  logic       RST, FLUSH, CLR_ERR, W_INC, R_INC;
  logic [7:0] WR_DATA;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  always #5 CLK = ~CLK;

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .FULL(full0), .EMPTY(empty0),
    .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0), .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .RD_DATA(rd_data1), .RD_VALID(rd_valid1), .FULL(full1), .EMPTY(empty1),
    .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: a queue of words plus sticky flags and the registered read port.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         m_rdv = 1'b0;
  logic [7:0] m_rdd = 8'h00;

  typedef struct {
    bit         clr;
    bit         w;
    logic [7:0] wd;
    bit         r;
    int         cnt;
    bit         full, empty, af, ae, ovf, rdv;
    logic [7:0] rdd;
  } vec_t;

  vec_t tv[36];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit rst, input bit flush, input bit clr, input bit w,
                       input logic [7:0] wd, input bit r);
    RST = rst; FLUSH = flush; CLR_ERR = clr; W_INC = w; WR_DATA = wd; R_INC = r;
  endtask

  task automatic model_step();
    bit mf, me;
    if (RST) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = 8'h00;
    end else if (FLUSH) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rdv = 0;
    end else begin
      mf = (q.size() == DEPTH);
      me = (q.size() == 0);
      if (W_INC && mf) m_ovf = 1; else if (CLR_ERR) m_ovf = 0;
      if (R_INC && me) m_unf = 1; else if (CLR_ERR) m_unf = 0;
      if (R_INC && !me) begin m_rdd = q.pop_front(); m_rdv = 1; end
      else m_rdv = 0;
      if (W_INC && !mf) q.push_back(WR_DATA);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, " count0"}, 32'(count0), n);
    chk({tag, " full0"}, 32'(full0), 32'(n == DEPTH));
    chk({tag, " empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, " af0"}, 32'(af0), 32'(n >= AF));
    chk({tag, " ae0"}, 32'(ae0), 32'(n <= AE));
    chk({tag, " ovf0"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, " unf0"}, 32'(unf0), 32'(m_unf));
    chk({tag, " rdv0"}, 32'(rd_valid0), 32'(m_rdv));
    chk({tag, " rdd0"}, 32'(rd_data0), 32'(m_rdd));
    chk({tag, " count1"}, 32'(count1), n);
    chk({tag, " full1"}, 32'(full1), 32'(n == DEPTH));
    chk({tag, " empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, " ovf1"}, 32'(ovf1), 32'(m_ovf));
    chk({tag, " unf1"}, 32'(unf1), 32'(m_unf));
    chk({tag, " rdv1"}, 32'(rd_valid1), 32'(n != 0));
    if (n != 0) chk({tag, " rdd1"}, 32'(rd_data1), 32'(q[0]));
  endtask

  task automatic step_chk(input string tag);
    cycle();
    check_model(tag);
  endtask

  initial begin
    // Fill/drain and overflow table (registered-read instance).
    for (int i = 0; i < 16; i++) begin
      tv[i] = '{clr: 0, w: 1, wd: 8'(i), r: 0, cnt: i + 1, full: (i == 15), empty: 0,
                af: (i + 1 >= AF), ae: (i + 1 <= AE), ovf: 0, rdv: 0, rdd: 8'h00};
    end
    tv[16] = '{clr: 0, w: 1, wd: 8'hAA, r: 0, cnt: 16, full: 1, empty: 0, af: 1, ae: 0, ovf: 1, rdv: 0, rdd: 8'h00};
    tv[17] = '{clr: 1, w: 0, wd: 8'h00, r: 0, cnt: 16, full: 1, empty: 0, af: 1, ae: 0, ovf: 0, rdv: 0, rdd: 8'h00};
    tv[18] = '{clr: 1, w: 1, wd: 8'hAA, r: 0, cnt: 16, full: 1, empty: 0, af: 1, ae: 0, ovf: 1, rdv: 0, rdd: 8'h00};
    tv[19] = '{clr: 1, w: 0, wd: 8'h00, r: 0, cnt: 16, full: 1, empty: 0, af: 1, ae: 0, ovf: 0, rdv: 0, rdd: 8'h00};
    for (int k = 0; k < 16; k++) begin
      tv[20 + k] = '{clr: 0, w: 0, wd: 8'h00, r: 1, cnt: 15 - k, full: 0, empty: (k == 15),
                     af: (15 - k >= AF), ae: (15 - k <= AE), ovf: 0, rdv: 1, rdd: 8'(k)};
    end

    // Reset state
    drive(1, 0, 0, 0, 8'h00, 0);
    cycle();
    drive(0, 0, 0, 0, 8'h00, 0);
    chk("reset count", 32'(count0), 0);
    chk("reset empty", 32'(empty0), 1);
    chk("reset full", 32'(full0), 0);
    chk("reset ae", 32'(ae0), 1);
    chk("reset af", 32'(af0), 0);
    chk("reset rdd", 32'(rd_data0), 0);
    chk("reset rdv", 32'(rd_valid0), 0);
    chk("reset rdv1", 32'(rd_valid1), 0);
    check_model("reset");

    for (int i = 0; i < 36; i++) begin
      drive(0, 0, tv[i].clr, tv[i].w, tv[i].wd, tv[i].r);
      cycle();
      chk($sformatf("vec%0d count", i), 32'(count0), tv[i].cnt);
      chk($sformatf("vec%0d full", i), 32'(full0), 32'(tv[i].full));
      chk($sformatf("vec%0d empty", i), 32'(empty0), 32'(tv[i].empty));
      chk($sformatf("vec%0d af", i), 32'(af0), 32'(tv[i].af));
      chk($sformatf("vec%0d ae", i), 32'(ae0), 32'(tv[i].ae));
      chk($sformatf("vec%0d ovf", i), 32'(ovf0), 32'(tv[i].ovf));
      chk($sformatf("vec%0d unf", i), 32'(unf0), 0);
      chk($sformatf("vec%0d rdv", i), 32'(rd_valid0), 32'(tv[i].rdv));
      chk($sformatf("vec%0d rdd", i), 32'(rd_data0), 32'(tv[i].rdd));
      check_model($sformatf("vec%0d", i));
    end

    drive(0, 0, 0, 0, 8'h00, 0);
    step_chk("idle");
    chk("idle rdv drops", 32'(rd_valid0), 0);

    // Underflow
    drive(0, 0, 0, 0, 8'h00, 1);
    step_chk("unf");
    chk("unf flag", 32'(unf0), 1);
    chk("unf count", 32'(count0), 0);
    drive(0, 0, 1, 0, 8'h00, 0);
    step_chk("unf clr");

    // Read plus write while empty: write taken, read rejected
    drive(0, 0, 0, 1, 8'h55, 1);
    step_chk("rw empty");
    chk("rw empty count", 32'(count0), 1);
    chk("rw empty no bypass", 32'(rd_valid0), 0);
    drive(0, 0, 1, 0, 8'h00, 1);
    step_chk("rd 55");
    chk("rd 55 data", 32'(rd_data0), 32'h55);

    // Read plus write at COUNT=5
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 8'(8'h10 + i), 0);
      step_chk("fill5");
    end
    drive(0, 0, 0, 1, 8'h15, 1);
    step_chk("rw5");
    chk("rw5 count", 32'(count0), 5);
    chk("rw5 data", 32'(rd_data0), 32'h10);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 8'h00, 1);
      step_chk("drain5");
      chk($sformatf("drain5 data%0d", i), 32'(rd_data0), 32'(8'h11 + i));
    end

    // FWFT: write into empty FIFO, visible next cycle without a read
    drive(0, 0, 0, 1, 8'h3C, 0);
    step_chk("fwft wr");
    chk("fwft valid", 32'(rd_valid1), 1);
    chk("fwft data", 32'(rd_data1), 32'h3C);
    drive(0, 0, 0, 0, 8'h00, 0);
    step_chk("fwft hold");
    chk("fwft hold data", 32'(rd_data1), 32'h3C);
    drive(0, 0, 0, 0, 8'h00, 1);
    step_chk("fwft pop");
    chk("fwft pop empty", 32'(empty1), 1);
    chk("fwft pop valid", 32'(rd_valid1), 0);

    // Flush mid-operation with concurrent requests
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1, 8'(8'h60 + i), 0);
      step_chk("fill9");
    end
    chk("fill9 count", 32'(count0), 9);
    drive(0, 1, 0, 1, 8'hEE, 1);
    step_chk("flush");
    chk("flush count", 32'(count0), 0);
    chk("flush empty", 32'(empty0), 1);
    chk("flush ovf", 32'(ovf0), 0);
    chk("flush unf", 32'(unf0), 0);
    chk("flush rdv", 32'(rd_valid0), 0);

    // Reset mid-operation
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1, 8'(8'h70 + i), 0);
      step_chk("refill9");
    end
    drive(1, 1, 0, 1, 8'hEE, 1);
    step_chk("rst");
    chk("rst count", 32'(count0), 0);
    chk("rst empty", 32'(empty0), 1);
    chk("rst full", 32'(full0), 0);
    chk("rst ae", 32'(ae0), 1);
    chk("rst af", 32'(af0), 0);
    chk("rst rdd", 32'(rd_data0), 0);
    chk("rst rdv", 32'(rd_valid0), 0);
    chk("rst ovf", 32'(ovf0), 0);
    chk("rst unf", 32'(unf0), 0);

    // Wrap-around: 40 write/read pairs with random gaps
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 1, 8'(i), 0);
      step_chk("wrap wr");
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive(0, 0, 0, 0, 8'h00, 0);
        step_chk("wrap gap");
      end
      drive(0, 0, 0, 0, 8'h00, 1);
      step_chk("wrap rd");
      chk($sformatf("wrap data%0d", i), 32'(rd_data0), 32'(i));
      chk($sformatf("wrap full%0d", i), 32'(full0), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 1) ? 75 : 30;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 100 - wp);
      step_chk($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
